channel_multiplexer_rr: RTL

Next-generation single-clock multiplexer that merges CHANN valid/ready source channels onto one GLIP FIFO output toward the host. Bursts are framed with a control word and a channel header.
- Fair round-robin arbitration with per-channel enables.
- Correct ready-gated reads in every state.
- Escaping of in-band control words.
- Optional header elision when the same channel is re-granted.
- Sits between on-chip producers (already synchronised to clk) and the GLIP target FIFO interface.

---
 rtl/channel_multiplexer_rr_pkg.sv | 15 +
 rtl/channel_multiplexer_rr_arbiter.sv | 39 +++
 rtl/channel_multiplexer_rr.sv | 138 +++++++++++++
 3 files changed

// File: rtl/channel_multiplexer_rr_pkg.sv
// Shared constants and state encoding for the GLIP channel multiplexer.
package glip_chmux_pkg;

   localparam logic [15:0] CONTROL_WORD          = 16'hC001;
   localparam logic [7:0]  CHANNEL_HEADER_PREFIX = 8'hAB;

   typedef enum logic [2:0] {
      IDLE,
      CTRL,
      HDR,
      DATA,
      ESC
   } state_t;

endpackage

// File: rtl/channel_multiplexer_rr_arbiter.sv
// Combinational round-robin arbiter: rotate, priority-encode, rotate back.
module rr_arbiter #(
   parameter  int N  = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   logic [IW:0]    w_start;
   logic [IW:0]    w_off;
   logic [IW:0]    w_sum;
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;

   always_comb begin
      w_start = {1'b0, last} + 1'b1;
      if (w_start >= (IW+1)'(N))
         w_start = '0;
      w_dbl = {req, req} >> w_start;
      w_rot = w_dbl[N-1:0];
      w_off     = '0;
      gnt_valid = 1'b0;
      // Descending scan so the lowest rotated index wins.
      for (int i = N-1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off     = (IW+1)'(i);
            gnt_valid = 1'b1;
         end
      end
      w_sum = w_start + w_off;
      if (w_sum >= (IW+1)'(N))
         w_sum = w_sum - (IW+1)'(N);
      gnt_idx = w_sum[IW-1:0];
   end

endmodule

// File: rtl/channel_multiplexer_rr.sv
// Round-robin merge of CHANN valid/ready sources onto one GLIP FIFO,
// with control-word framing, escaping and optional header elision.
module channel_multiplexer_rr
   import glip_chmux_pkg::*;
#(
   parameter  int WIDTH        = 16,
   parameter  int CHANN        = 8,
   parameter  int TIMEOUT      = 32,
   parameter  int HEADER_ELIDE = 1,
   localparam int CW = (CHANN > 1) ? $clog2(CHANN) : 1,
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1
) (
   input  logic                        clk,
   input  logic                        com_rst,
   input  logic [CHANN-1:0]            channel_enable,
   input  logic [CHANN-1:0]            in_valid,
   output logic [CHANN-1:0]            in_ready,
   input  logic [CHANN-1:0][WIDTH-1:0] in_data,
   output logic                        fifo_out_valid,
   input  logic                        fifo_out_ready,
   output logic [WIDTH-1:0]            fifo_out_data,
   output logic [CW-1:0]               active_channel,
   output logic                        busy
);

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_ch;
   logic [CW-1:0]  r_last;
   logic [TW-1:0]  r_cnt;
   logic           r_hdr_valid;

   logic           w_gnt_valid;
   logic [CW-1:0]  w_gnt_idx;
   logic           w_eob;
   logic           w_xfer;
   logic [7:0]     w_ch8;

   rr_arbiter #(.N(CHANN)) u_arb (
      .req       (in_valid & channel_enable),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_ch8          = 8'(r_ch);
   assign w_xfer         = fifo_out_valid & fifo_out_ready;
   assign active_channel = r_ch;
   assign busy           = (r_state != IDLE);

   always_comb begin
      w_next         = r_state;
      fifo_out_valid = 1'b0;
      fifo_out_data  = '0;
      in_ready       = '0;
      w_eob          = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               if (HEADER_ELIDE != 0 && r_hdr_valid && w_gnt_idx == r_last)
                  w_next = DATA;
               else
                  w_next = CTRL;
            end
         end
         CTRL: begin
            fifo_out_valid = 1'b1;
            fifo_out_data  = WIDTH'(CONTROL_WORD);
            if (fifo_out_ready)
               w_next = HDR;
         end
         HDR: begin
            fifo_out_valid = 1'b1;
            fifo_out_data  = WIDTH'({CHANNEL_HEADER_PREFIX, w_ch8});
            if (fifo_out_ready)
               w_next = DATA;
         end
         DATA: begin
            w_eob = !in_valid[r_ch] ||
                    (TIMEOUT != 0 && r_cnt == TW'(TIMEOUT));
            if (w_eob) begin
               w_next = IDLE;
            end else begin
               fifo_out_valid = 1'b1;
               fifo_out_data  = in_data[r_ch];
               in_ready[r_ch] = fifo_out_ready;
               // An in-band control word is doubled on the wire.
               if (fifo_out_ready && in_data[r_ch] == WIDTH'(CONTROL_WORD))
                  w_next = ESC;
            end
         end
         ESC: begin
            fifo_out_valid = 1'b1;
            fifo_out_data  = WIDTH'(CONTROL_WORD);
            if (fifo_out_ready)
               w_next = DATA;
         end
         default: w_next = IDLE;
      endcase
      // Nothing may be offered or consumed while reset is applied.
      if (com_rst) begin
         fifo_out_valid = 1'b0;
         in_ready       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (com_rst) begin
         r_state     <= IDLE;
         r_ch        <= '0;
         r_last      <= CW'(CHANN-1);
         r_cnt       <= '0;
         r_hdr_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               if (w_gnt_valid)
                  r_ch <= w_gnt_idx;
            end
            HDR: begin
               if (w_xfer)
                  r_hdr_valid <= 1'b1;
            end
            DATA: begin
               if (w_eob) begin
                  r_last <= r_ch;
                  r_cnt  <= '0;
               end else if (w_xfer && TIMEOUT != 0) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
